// File: rtl/bbox_tracker.sv
// bbox_tracker: per-frame bounding box of foreground mask pixels, committed at end of frame.
// Define BBOX_SMOOTH_EN to average consecutive detections instead of loading raw boxes.
module bbox_tracker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic             mask_in,
  output logic [15:0]      bbox_x_min,
  output logic [15:0]      bbox_x_max,
  output logic [15:0]      bbox_y_min,
  output logic [15:0]      bbox_y_max,
  output logic             object_found,
  output logic             bbox_valid,
  output logic [CNT_W-1:0] pixel_count
);
  typedef enum logic [1:0] {IDLE, ACTIVE, UPDATE} state_t;
  state_t state_q, state_d;
  logic vs_q;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
  logic [15:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d, by_min_q, by_min_d, by_max_q, by_max_d;
  logic [15:0] nx_min, nx_max, ny_min, ny_max;
  logic found_q, found_d, valid_q;
  logic start, acc, qual, upd, hit;
`ifdef BBOX_SMOOTH_EN
  function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16:1];
  endfunction
`endif
  always_comb begin
    start = state_q == IDLE && v_sync && !vs_q;
    acc = state_q == ACTIVE || start;
    qual = acc && v_sync && h_sync && mask_in && y_q <= 16'(V_ACTIVE - 1);
    upd = state_q == UPDATE;
    hit = upd && cnt_q >= CNT_W'(MIN_PIXELS);
    x_d = !v_sync ? 16'd0 : !h_sync ? x_q : x_q == 16'(H_ACTIVE - 1) ? 16'd0 : x_q + 16'd1;
    y_d = !v_sync ? 16'd0 : (h_sync && x_q == 16'(H_ACTIVE - 1)) ? y_q + 16'd1 : y_q;
    min_x_d = !acc ? 16'hFFFF : (qual && x_q < min_x_q) ? x_q : min_x_q;
    max_x_d = !acc ? 16'd0 : (qual && x_q > max_x_q) ? x_q : max_x_q;
    min_y_d = !acc ? 16'hFFFF : (qual && y_q < min_y_q) ? y_q : min_y_q;
    max_y_d = !acc ? 16'd0 : (qual && y_q > max_y_q) ? y_q : max_y_q;
    cnt_d = !acc ? '0 : (qual && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    state_d = start ? ACTIVE
            : (state_q == ACTIVE && !v_sync) ? UPDATE
            : upd ? (v_sync ? ACTIVE : IDLE)
            : state_q;
`ifdef BBOX_SMOOTH_EN
    nx_min = found_q ? avg(bx_min_q, min_x_q) : min_x_q;
    nx_max = found_q ? avg(bx_max_q, max_x_q) : max_x_q;
    ny_min = found_q ? avg(by_min_q, min_y_q) : min_y_q;
    ny_max = found_q ? avg(by_max_q, max_y_q) : max_y_q;
`else
    nx_min = min_x_q;
    nx_max = max_x_q;
    ny_min = min_y_q;
    ny_max = max_y_q;
`endif
    bx_min_d = hit ? nx_min : bx_min_q;
    bx_max_d = hit ? nx_max : bx_max_q;
    by_min_d = hit ? ny_min : by_min_q;
    by_max_d = hit ? ny_max : by_max_q;
    found_d = upd ? hit : found_q;
    count_d = upd ? cnt_q : count_q;
  end
  // vs_q resets high so a frame already running at reset release is not mistaken for a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vs_q <= 1'b1;
      x_q <= '0;
      y_q <= '0;
      min_x_q <= 16'hFFFF;
      max_x_q <= '0;
      min_y_q <= 16'hFFFF;
      max_y_q <= '0;
      cnt_q <= '0;
      bx_min_q <= '0;
      bx_max_q <= '0;
      by_min_q <= '0;
      by_max_q <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q <= v_sync;
      x_q <= x_d;
      y_q <= y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q <= cnt_d;
      bx_min_q <= bx_min_d;
      bx_max_q <= bx_max_d;
      by_min_q <= by_min_d;
      by_max_q <= by_max_d;
      found_q <= found_d;
      valid_q <= upd;
      count_q <= count_d;
    end
  end
  assign bbox_x_min = bx_min_q;
  assign bbox_x_max = bx_max_q;
  assign bbox_y_min = by_min_q;
  assign bbox_y_max = by_max_q;
  assign object_found = found_q;
  assign bbox_valid = valid_q;
  assign pixel_count = count_q;
endmodule
